// File: rtl/aer_pkg.sv
// Shared definitions for the AER spike encoder: event field widths, the {ts, addr}
// packing order and the lowest-set-bit priority encoder.
package aer_pkg;

    localparam int unsigned AER_ADDR_W = 3;
    localparam int unsigned AER_TS_W   = 8;
    localparam int unsigned AER_EV_W   = AER_TS_W + AER_ADDR_W;

    // Timestep occupies the MSBs of a packed event.
    typedef struct packed {
        logic [AER_TS_W-1:0]   ts;
        logic [AER_ADDR_W-1:0] addr;
    } aer_event_t;

    function automatic aer_event_t aer_pack(input logic [AER_TS_W-1:0]   ts,
                                            input logic [AER_ADDR_W-1:0] addr);
        aer_event_t ev;
        ev.ts   = ts;
        ev.addr = addr;
        return ev;
    endfunction

    function automatic logic [AER_TS_W-1:0] aer_unpack_ts(input aer_event_t ev);
        return ev.ts;
    endfunction

    function automatic logic [AER_ADDR_W-1:0] aer_unpack_addr(input aer_event_t ev);
        return ev.addr;
    endfunction

    // Index of the lowest set bit; 0 when the vector is all zero.
    function automatic int unsigned aer_lowest_set(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/aer_fifo.sv
// Synchronous event FIFO with occupancy counter; pushes are refused when full and
// pops refused when empty, both judged on the occupancy at the start of the cycle.
module aer_fifo
    import aer_pkg::*;
#(
    parameter int unsigned WIDTH = AER_EV_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Turns a per-timestep spike vector into a stream of {timestep, address} events,
// one per cycle in ascending address order, buffered behind a valid/ready port.
module spike_aer_encoder
    import aer_pkg::*;
#(
    parameter int unsigned N_NEURONS  = 8,
    parameter int unsigned ADDR_W     = AER_ADDR_W,
    parameter int unsigned TS_W       = AER_TS_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic [N_NEURONS-1:0] spikes,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [ADDR_W-1:0]    ev_addr,
    output logic [TS_W-1:0]      ev_ts,
    output logic                 busy,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    logic [N_NEURONS-1:0] pending_q, pending_d;
    logic [TS_W-1:0]      ts_q, cur_ts_q;
    logic                 overflow_q, overflow_d;
    logic                 pending_any;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;
    logic [ADDR_W-1:0]    scan_addr;
    aer_event_t           push_ev, head_ev;

    assign pending_any = |pending_q;
    assign scan_addr   = ADDR_W'(aer_lowest_set(32'(pending_q)));
    assign push_ev     = aer_pack(cur_ts_q, scan_addr);

    // A step edge never pushes: the old vector is either empty or being discarded.
    assign push = pending_any && !fifo_full && !step;
    assign pop  = !fifo_empty && ev_ready;

    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (step) begin
            pending_d = spikes;
            if (pending_any) overflow_d = 1'b1;
        end else if (push) begin
            // Clears the lowest set bit, i.e. the one just encoded.
            pending_d = pending_q & (pending_q - N_NEURONS'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            ts_q       <= '0;
            cur_ts_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (step) begin
                cur_ts_q <= ts_q;
                ts_q     <= ts_q + TS_W'(1);
            end
        end
    end

    aer_fifo #(
        .WIDTH (AER_EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_ev),
        .pop   (pop),
        .rdata (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_addr  = aer_unpack_addr(head_ev);
    assign ev_ts    = aer_unpack_ts(head_ev);
    assign busy     = pending_any || ev_valid;
    assign overflow = overflow_q;

endmodule
